// File: rtl/pwm_output_stage.sv
// pwm_output_stage
//   Sixteen-channel output driver. Each channel is off, static high, or
//   driven by one shared PWM waveform. A prescaler divides clk into PWM
//   ticks. An 8-bit counter advances on each tick, so one period is
//   256 ticks. The duty value passes through a shadow register that is
//   only reloaded at the period boundary, which keeps waveforms
//   glitch-free.
//
// Parameters
//   CLK_DIV           clk cycles per PWM tick (>= 1)
// Ports
//   clk               system clock, posedge
//   rst_n             asynchronous active-low reset
//   en_out_7_0        channel enable, bits 7:0
//   en_out_15_8       channel enable, bits 15:8
//   en_pwm_mode_7_0   1 = PWM, 0 = static high, bits 7:0
//   en_pwm_mode_15_8  same, bits 15:8
//   pwm_duty_cycle    requested duty, 0x00 = 0 %, 0xFF = 100 %
//   out               registered channel outputs
//   period_start      one-clk pulse in the first cycle of each period

// Per-channel output register: off, static high, or PWM.
module pwm_output_lane (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic mode,
    input  logic pwm_level,
    output logic out
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) out <= 1'b0;
        else        out <= en & (~mode | pwm_level);
    end
endmodule

module pwm_output_stage #(
    parameter int CLK_DIV = 3000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  en_out_7_0,
    input  logic [7:0]  en_out_15_8,
    input  logic [7:0]  en_pwm_mode_7_0,
    input  logic [7:0]  en_pwm_mode_15_8,
    input  logic [7:0]  pwm_duty_cycle,
    output logic [15:0] out,
    output logic        period_start
);
    localparam int NUM_LANES = 16;
    localparam int PW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [PW-1:0]          prescaler;
    logic                   tick;
    logic [7:0]             pwm_cnt;
    logic [7:0]             duty_shadow;
    logic                   boundary;
    logic                   pwm_level;
    logic [NUM_LANES-1:0]   en;
    logic [NUM_LANES-1:0]   mode;

    assign en   = {en_out_15_8, en_out_7_0};
    assign mode = {en_pwm_mode_15_8, en_pwm_mode_7_0};

    // With CLK_DIV = 1 the 1-bit prescaler sits at 0 and tick is always high.
    assign tick     = (prescaler == PW'(CLK_DIV - 1));
    // Last tick of a period: pwm_cnt wraps and the shadow reloads on this edge.
    assign boundary = tick && (pwm_cnt == 8'hFF);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler    <= '0;
            pwm_cnt      <= 8'h00;
            duty_shadow  <= 8'h00;
            period_start <= 1'b0;
        end else begin
            prescaler    <= tick ? '0 : prescaler + 1'b1;
            if (tick)     pwm_cnt     <= pwm_cnt + 8'h01;
            if (boundary) duty_shadow <= pwm_duty_cycle;
            period_start <= boundary;
        end
    end

    // 0xFF is special-cased so full duty never drops low at pwm_cnt = 255.
    assign pwm_level = (duty_shadow == 8'hFF) || (pwm_cnt < duty_shadow);

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        pwm_output_lane u_lane (
            .clk       (clk),
            .rst_n     (rst_n),
            .en        (en[i]),
            .mode      (mode[i]),
            .pwm_level (pwm_level),
            .out       (out[i])
        );
    end
endmodule

// File: tb/tb_pwm_output_stage.sv
// Bench for pwm_output_stage: one instance with CLK_DIV = 4 and one with
// CLK_DIV = 1, sharing all inputs.
module tb_pwm_output_stage;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] en = 16'h0000;
    logic [15:0] mode = 16'h0000;
    logic [7:0]  duty = 8'h00;
    logic [15:0] out4, out1;
    logic        ps4, ps1;

    int vectors = 0;
    int fails = 0;

    always #5 clk = ~clk;

    pwm_output_stage #(.CLK_DIV(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .en_out_7_0(en[7:0]), .en_out_15_8(en[15:8]),
        .en_pwm_mode_7_0(mode[7:0]), .en_pwm_mode_15_8(mode[15:8]),
        .pwm_duty_cycle(duty), .out(out4), .period_start(ps4)
    );

    pwm_output_stage #(.CLK_DIV(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .en_out_7_0(en[7:0]), .en_out_15_8(en[15:8]),
        .en_pwm_mode_7_0(mode[7:0]), .en_pwm_mode_15_8(mode[15:8]),
        .pwm_duty_cycle(duty), .out(out1), .period_start(ps1)
    );

    typedef struct {
        logic [15:0] en;
        logic [15:0] mode;
        logic [7:0]  duty;
        logic [15:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Wait (bounded) until the selected instance pulses period_start.
    task automatic wait_ps(input bit sel);
        bit seen = 1'b0;
        for (int n = 0; n < 2000 && !seen; n++) begin
            @(posedge clk); #1;
            seen = sel ? ps1 : ps4;
        end
        check("wait_period_start", {31'd0, seen}, 32'd1);
    endtask

    // Samples `len` cycles starting right after a period_start cycle.
    // Each sample is classified as all-PWM-high, all-PWM-low or bad (static
    // bits wrong, PWM bits mixed, or period_start at the wrong place).
    // Optional duty writes happen at sample wk1 / wk2 (0 = none).
    task automatic run_period(input bit sel, input int len,
                              input int wk1, input logic [7:0] wv1,
                              input int wk2, input logic [7:0] wv2,
                              output int hi, output int lo, output int bad);
        logic [15:0] stat, pmask, o;
        logic        p;
        stat  = en & ~mode;
        pmask = en & mode;
        hi = 0; lo = 0; bad = 0;
        for (int k = 1; k <= len; k++) begin
            @(posedge clk); #1;
            o = sel ? out1 : out4;
            p = sel ? ps1 : ps4;
            if (o == (stat | pmask)) hi++;
            else if (o == stat)      lo++;
            else                     bad++;
            if (p != (k == len)) bad++;
            if (k == wk1) duty = wv1;
            if (k == wk2) duty = wv2;
        end
    endtask

    task automatic check_period(input string name, input bit sel, input int len,
                                input int wk1, input logic [7:0] wv1,
                                input int wk2, input logic [7:0] wv2,
                                input int exp_hi);
        int hi, lo, bad;
        run_period(sel, len, wk1, wv1, wk2, wv2, hi, lo, bad);
        check({name, "_hi"},  hi,  exp_hi);
        check({name, "_lo"},  lo,  len - exp_hi);
        check({name, "_bad"}, bad, 0);
    endtask

    initial begin
        vec_t tbl[6];
        int hi, lo, bad;
        int n4, n1;

        // Static vectors run inside the first period after reset, where the
        // duty shadow is still 0 so PWM channels read low.
        tbl[0] = '{16'h00A5, 16'h0000, 8'h00, 16'h00A5};
        tbl[1] = '{16'h0000, 16'h0000, 8'h00, 16'h0000};
        tbl[2] = '{16'hFFFF, 16'hFF00, 8'h00, 16'h00FF};
        tbl[3] = '{16'h0F0F, 16'h00FF, 8'h40, 16'h0F00};
        tbl[4] = '{16'hFFFF, 16'hFFFF, 8'hFF, 16'h0000};
        tbl[5] = '{16'hFFFF, 16'h0000, 8'h80, 16'hFFFF};

        #1;
        check("reset_out4", out4, 16'h0000);
        check("reset_ps4",  ps4,  1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            en = tbl[i].en; mode = tbl[i].mode; duty = tbl[i].duty;
            @(posedge clk); #1;
            check($sformatf("static%0d_out4", i), out4, tbl[i].exp);
            check($sformatf("static%0d_out1", i), out1, tbl[i].exp);
        end

        // 50 % duty, then a mid-period change and a double write.
        en = 16'hFFFF; mode = 16'hFFFF; duty = 8'h80;
        wait_ps(0);
        check_period("duty80",     0, 1024, 0,   8'h00, 0,   8'h00, 512);
        check_period("mid_write",  0, 1024, 64,  8'h40, 0,   8'h00, 512);
        check_period("after_40",   0, 1024, 100, 8'h20, 300, 8'h60, 256);
        check_period("only_60",    0, 1024, 0,   8'h00, 0,   8'h00, 384);

        duty = 8'h00;
        run_period(0, 1024, 0, 8'h00, 0, 8'h00, hi, lo, bad);
        check_period("duty00",     0, 1024, 0,   8'h00, 0,   8'h00, 0);

        duty = 8'hFF;
        run_period(0, 1024, 0, 8'h00, 0, 8'h00, hi, lo, bad);
        check_period("dutyFF_a",   0, 1024, 0,   8'h00, 0,   8'h00, 1024);
        check_period("dutyFF_b",   0, 1024, 0,   8'h00, 0,   8'h00, 1024);

        // Mixed: bits 3:0 PWM, 11:8 static high, the rest off.
        en = 16'h0F0F; mode = 16'h00FF; duty = 8'h40;
        run_period(0, 1024, 0, 8'h00, 0, 8'h00, hi, lo, bad);
        check_period("mixed",      0, 1024, 0,   8'h00, 0,   8'h00, 256);

        // CLK_DIV = 1: duty 0x01 gives exactly one high clk per 256.
        en = 16'hFFFF; mode = 16'hFFFF; duty = 8'h01;
        wait_ps(1);
        check_period("div1_a",     1, 256,  0,   8'h00, 0,   8'h00, 1);
        check_period("div1_b",     1, 256,  0,   8'h00, 0,   8'h00, 1);

        // Asynchronous reset mid-period while outputs are high.
        duty = 8'h80;
        wait_ps(0);
        wait_ps(0);
        repeat (10) @(posedge clk);
        #1;
        check("pre_reset_out4", out4, 16'hFFFF);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_out4", out4, 16'h0000);
        check("async_reset_out1", out1, 16'h0000);
        check("async_reset_ps4",  ps4,  1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        n4 = 0; n1 = 0;
        for (int n = 1; n <= 1100 && n4 == 0; n++) begin
            @(posedge clk); #1;
            if (ps1 && n1 == 0) n1 = n;
            if (ps4) n4 = n;
        end
        check("first_ps_div4", n4, 1024);
        check("first_ps_div1", n1, 256);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule
